// File: rtl/risc_v_ex_mem_wb.sv
// RV32I back end: EX, MEM and WB stages with forwarding, branch squash and word-only data memory.
// Latency: ID capture -> PCSrc/PC_Branch 1 cycle; ID capture -> RegWrite_WB/ALU_DATA_WB 3 cycles.
// Backpressure: none; every stage advances each cycle, load-use stalls are left to the front end.
//
// Ports:
//   clk, reset                      single clock, synchronous active-high reset
//   PC_ID .. ALUop_ID               decoded instruction and register operands from ID
//   PCSrc, PC_Branch                taken-branch flag and target, driven from EX state
//   RegWrite_WB, ALU_DATA_WB, RD_WB register-file write port
//   MemRead_EX, RD_EX               EX-stage load info for the hazard unit
module risc_v_ex_mem_wb #(
   parameter int DMEM_WORDS = 64
) (
   input  logic        clk,
   input  logic        reset,
   input  logic [31:0] PC_ID,
   input  logic [31:0] IMM_ID,
   input  logic [31:0] REG_DATA1_ID,
   input  logic [31:0] REG_DATA2_ID,
   input  logic [2:0]  FUNCT3_ID,
   input  logic [6:0]  FUNCT7_ID,
   input  logic [4:0]  RD_ID,
   input  logic [4:0]  RS1_ID,
   input  logic [4:0]  RS2_ID,
   input  logic        RegWrite_ID,
   input  logic        MemtoReg_ID,
   input  logic        MemRead_ID,
   input  logic        MemWrite_ID,
   input  logic        ALUSrc_ID,
   input  logic        Branch_ID,
   input  logic [1:0]  ALUop_ID,
   output logic        PCSrc,
   output logic [31:0] PC_Branch,
   output logic        RegWrite_WB,
   output logic [31:0] ALU_DATA_WB,
   output logic [4:0]  RD_WB,
   output logic        MemRead_EX,
   output logic [4:0]  RD_EX
);

   localparam int AW = $clog2(DMEM_WORDS);

   typedef struct packed {
      logic [31:0] pc;
      logic [31:0] imm;
      logic [31:0] rd1;
      logic [31:0] rd2;
      logic [2:0]  funct3;
      logic        f7_alt;      // funct7[5]: selects sub / sra
      logic [4:0]  rd;
      logic [4:0]  rs1;
      logic [4:0]  rs2;
      logic        reg_write;
      logic        mem_to_reg;
      logic        mem_read;
      logic        mem_write;
      logic        alu_src;
      logic        branch;
      logic [1:0]  alu_op;
   } idex_t;

   typedef struct packed {
      logic [31:0] alu;
      logic [31:0] store_data;
      logic [4:0]  rd;
      logic        reg_write;
      logic        mem_to_reg;
      logic        mem_write;
   } exmem_t;

   typedef struct packed {
      logic [31:0] alu;
      logic [31:0] load;
      logic [4:0]  rd;
      logic        reg_write;
      logic        mem_to_reg;
   } memwb_t;

   typedef enum logic {S_IDLE, S_SQUASH} sq_state_e;

   sq_state_e   state_q, state_d;
   logic        squash;
   idex_t       idex_q, idex_d;
   exmem_t      exmem_q, exmem_d;
   memwb_t      memwb_q, memwb_d;
   logic [31:0] dmem_q [DMEM_WORDS];

   logic [31:0] ex_rs1, ex_rs2, alu_a, alu_b, alu_res;
   logic [4:0]  shamt;
   logic        br_taken;
   logic [AW-1:0] mem_idx;
   logic        funct7_unused;

   // Only funct7[5] carries meaning for the supported ops.
   assign funct7_unused = ^{FUNCT7_ID[6], FUNCT7_ID[4:0]};

   // ---------------------------------------------------------------- squash FSM
   // A taken branch kills the two instructions fetched behind it: the one
   // being captured this cycle and the one captured next cycle.
   always_comb begin
      state_d = state_q;
      squash  = 1'b0;
      case (state_q)
         S_IDLE: begin
            if (PCSrc) begin
               squash  = 1'b1;
               state_d = S_SQUASH;
            end
         end
         S_SQUASH: begin
            squash  = 1'b1;
            state_d = S_IDLE;
         end
         default: state_d = S_IDLE;
      endcase
   end

   // ---------------------------------------------------------------- ID/EX capture
   // The write-back port lands in the register file at the same edge this
   // capture happens, so the file read in ID is stale; bypass it here.
   always_comb begin
      idex_d = '0;
      if (!squash) begin
         idex_d.pc         = PC_ID;
         idex_d.imm        = IMM_ID;
         idex_d.rd1        = (RegWrite_WB && RD_WB != 5'd0 && RD_WB == RS1_ID) ? ALU_DATA_WB : REG_DATA1_ID;
         idex_d.rd2        = (RegWrite_WB && RD_WB != 5'd0 && RD_WB == RS2_ID) ? ALU_DATA_WB : REG_DATA2_ID;
         idex_d.funct3     = FUNCT3_ID;
         idex_d.f7_alt     = FUNCT7_ID[5];
         idex_d.rd         = RD_ID;
         idex_d.rs1        = RS1_ID;
         idex_d.rs2        = RS2_ID;
         idex_d.reg_write  = RegWrite_ID;
         idex_d.mem_to_reg = MemtoReg_ID;
         idex_d.mem_read   = MemRead_ID;
         idex_d.mem_write  = MemWrite_ID;
         idex_d.alu_src    = ALUSrc_ID;
         idex_d.branch     = Branch_ID;
         idex_d.alu_op     = ALUop_ID;
      end
   end

   // ---------------------------------------------------------------- EX
   // Youngest producer wins: EX/MEM result, then the write-back value.
   always_comb begin
      if (exmem_q.reg_write && exmem_q.rd != 5'd0 && exmem_q.rd == idex_q.rs1)
         ex_rs1 = exmem_q.alu;
      else if (memwb_q.reg_write && memwb_q.rd != 5'd0 && memwb_q.rd == idex_q.rs1)
         ex_rs1 = ALU_DATA_WB;
      else
         ex_rs1 = idex_q.rd1;

      if (exmem_q.reg_write && exmem_q.rd != 5'd0 && exmem_q.rd == idex_q.rs2)
         ex_rs2 = exmem_q.alu;
      else if (memwb_q.reg_write && memwb_q.rd != 5'd0 && memwb_q.rd == idex_q.rs2)
         ex_rs2 = ALU_DATA_WB;
      else
         ex_rs2 = idex_q.rd2;
   end

   assign alu_a = ex_rs1;
   assign alu_b = idex_q.alu_src ? idex_q.imm : ex_rs2;
   assign shamt = alu_b[4:0];

   always_comb begin
      alu_res = alu_a + alu_b;
      if (idex_q.alu_op == 2'b10) begin
         case (idex_q.funct3)
            3'b000: alu_res = (idex_q.f7_alt && !idex_q.alu_src) ? alu_a - alu_b : alu_a + alu_b;
            3'b001: alu_res = alu_a << shamt;
            3'b010: alu_res = {31'd0, $signed(alu_a) < $signed(alu_b)};
            3'b011: alu_res = {31'd0, alu_a < alu_b};
            3'b100: alu_res = alu_a ^ alu_b;
            3'b101: alu_res = idex_q.f7_alt ? 32'($signed(alu_a) >>> shamt) : alu_a >> shamt;
            3'b110: alu_res = alu_a | alu_b;
            3'b111: alu_res = alu_a & alu_b;
            default: alu_res = alu_a + alu_b;
         endcase
      end
   end

   always_comb begin
      br_taken = 1'b0;
      case (idex_q.funct3)
         3'b000: br_taken = (ex_rs1 == ex_rs2);
         3'b001: br_taken = (ex_rs1 != ex_rs2);
         3'b100: br_taken = ($signed(ex_rs1) <  $signed(ex_rs2));
         3'b101: br_taken = ($signed(ex_rs1) >= $signed(ex_rs2));
         3'b110: br_taken = (ex_rs1 <  ex_rs2);
         3'b111: br_taken = (ex_rs1 >= ex_rs2);
         default: br_taken = 1'b0;
      endcase
   end

   assign PCSrc      = idex_q.branch & br_taken;
   assign PC_Branch  = idex_q.pc + idex_q.imm;
   assign MemRead_EX = idex_q.mem_read;
   assign RD_EX      = idex_q.rd;

   always_comb begin
      exmem_d            = '0;
      exmem_d.alu        = alu_res;
      exmem_d.store_data = ex_rs2;
      exmem_d.rd         = idex_q.rd;
      exmem_d.reg_write  = idex_q.reg_write;
      exmem_d.mem_to_reg = idex_q.mem_to_reg;
      exmem_d.mem_write  = idex_q.mem_write;
   end

   // ---------------------------------------------------------------- MEM
   // Word index only; byte offset and high address bits are dropped.
   assign mem_idx = exmem_q.alu[AW+1:2];

   always_ff @(posedge clk) begin
      if (!reset && exmem_q.mem_write)
         dmem_q[mem_idx] <= exmem_q.store_data;
   end

   always_comb begin
      memwb_d            = '0;
      memwb_d.alu        = exmem_q.alu;
      memwb_d.load       = dmem_q[mem_idx];
      memwb_d.rd         = exmem_q.rd;
      memwb_d.reg_write  = exmem_q.reg_write;
      memwb_d.mem_to_reg = exmem_q.mem_to_reg;
   end

   // ---------------------------------------------------------------- WB
   assign RegWrite_WB = memwb_q.reg_write && (memwb_q.rd != 5'd0);
   assign ALU_DATA_WB = memwb_q.mem_to_reg ? memwb_q.load : memwb_q.alu;
   assign RD_WB       = memwb_q.rd;

   // ---------------------------------------------------------------- state
   always_ff @(posedge clk) begin
      if (reset) begin
         state_q <= S_IDLE;
         idex_q  <= '0;
         exmem_q <= '0;
         memwb_q <= '0;
      end else begin
         state_q <= state_d;
         idex_q  <= idex_d;
         exmem_q <= exmem_d;
         memwb_q <= memwb_d;
      end
   end

endmodule

// File: tb/tb_risc_v_ex_mem_wb.sv
// Bench for risc_v_ex_mem_wb: instruction-level reference model feeds expectation queues,
// a negedge monitor pops them when the DUT writes back or takes a branch.
// The bench also plays the external register file, written from the DUT write-back port.
module tb_risc_v_ex_mem_wb;

   localparam int DW = 64;

   logic        clk = 1'b0;
   logic        reset;
   logic [31:0] PC_ID, IMM_ID, REG_DATA1_ID, REG_DATA2_ID;
   logic [2:0]  FUNCT3_ID;
   logic [6:0]  FUNCT7_ID;
   logic [4:0]  RD_ID, RS1_ID, RS2_ID;
   logic        RegWrite_ID, MemtoReg_ID, MemRead_ID, MemWrite_ID, ALUSrc_ID, Branch_ID;
   logic [1:0]  ALUop_ID;
   logic        PCSrc;
   logic [31:0] PC_Branch;
   logic        RegWrite_WB;
   logic [31:0] ALU_DATA_WB;
   logic [4:0]  RD_WB;
   logic        MemRead_EX;
   logic [4:0]  RD_EX;

   always #5 clk = ~clk;

   risc_v_ex_mem_wb #(.DMEM_WORDS(DW)) dut (
      .clk(clk), .reset(reset),
      .PC_ID(PC_ID), .IMM_ID(IMM_ID), .REG_DATA1_ID(REG_DATA1_ID), .REG_DATA2_ID(REG_DATA2_ID),
      .FUNCT3_ID(FUNCT3_ID), .FUNCT7_ID(FUNCT7_ID),
      .RD_ID(RD_ID), .RS1_ID(RS1_ID), .RS2_ID(RS2_ID),
      .RegWrite_ID(RegWrite_ID), .MemtoReg_ID(MemtoReg_ID), .MemRead_ID(MemRead_ID),
      .MemWrite_ID(MemWrite_ID), .ALUSrc_ID(ALUSrc_ID), .Branch_ID(Branch_ID), .ALUop_ID(ALUop_ID),
      .PCSrc(PCSrc), .PC_Branch(PC_Branch), .RegWrite_WB(RegWrite_WB), .ALU_DATA_WB(ALU_DATA_WB),
      .RD_WB(RD_WB), .MemRead_EX(MemRead_EX), .RD_EX(RD_EX)
   );

   typedef struct packed {
      logic [31:0] pc;
      logic [31:0] imm;
      logic [2:0]  f3;
      logic        f7b5;
      logic [4:0]  rd;
      logic [4:0]  rs1;
      logic [4:0]  rs2;
      logic        rw, m2r, mr, mw, asrc, br;
      logic [1:0]  op;
   } ins_t;

   typedef struct packed { logic [31:0] cyc; logic [4:0] rd; logic [31:0] val; } wb_exp_t;
   typedef struct packed { logic [31:0] cyc; logic [31:0] tgt; } br_exp_t;

   wb_exp_t     wbq[$];
   br_exp_t     brq[$];
   int          checks = 0;
   int          errors = 0;
   int          cyc = 0;
   logic        mon_en = 1'b0;
   logic        rf_clear = 1'b1;

   logic [31:0] hw_rf [32];   // external register file seen by ID
   logic [31:0] rf_m  [32];   // architectural registers of the reference model
   logic [31:0] mem_m [DW];   // architectural data memory of the reference model
   int          skip = 0;     // wrong-path instructions still to be discarded

   always @(posedge clk) cyc <= cyc + 1;

   always @(posedge clk) begin
      if (rf_clear) begin
         for (int i = 0; i < 32; i++) hw_rf[i] <= '0;
      end else if (RegWrite_WB && RD_WB != 5'd0) begin
         hw_rf[RD_WB] <= ALU_DATA_WB;
      end
   end

   task automatic chk(input string nm, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s got=%h expected=%h", nm, got, exp);
      end
   endtask

   // ------------------------------------------------------------ reference model
   function automatic int widx(input logic [31:0] addr);
      return int'((addr >> 2) % DW);
   endfunction

   function automatic logic [31:0] ref_alu(input ins_t i, input logic [31:0] a, input logic [31:0] b);
      int sh;
      sh = int'(b % 32);
      if (i.op != 2'b10) return a + b;
      case (i.f3)
         3'd0: return (i.f7b5 && !i.asrc) ? a - b : a + b;
         3'd1: return a << sh;
         3'd2: return ($signed(a) < $signed(b)) ? 32'd1 : 32'd0;
         3'd3: return (a < b) ? 32'd1 : 32'd0;
         3'd4: return a ^ b;
         3'd5: return i.f7b5 ? 32'($signed(a) >>> sh) : a >> sh;
         3'd6: return a | b;
         default: return a & b;
      endcase
   endfunction

   function automatic logic ref_taken(input logic [2:0] f3, input logic [31:0] a, input logic [31:0] b);
      case (f3)
         3'd0: return a == b;
         3'd1: return a != b;
         3'd4: return $signed(a) < $signed(b);
         3'd5: return $signed(a) >= $signed(b);
         3'd6: return a < b;
         3'd7: return a >= b;
         default: return 1'b0;
      endcase
   endfunction

   task automatic model(input ins_t i);
      logic [31:0] a, b2, res, val;
      wb_exp_t we;
      br_exp_t be;
      if (skip > 0) begin
         skip--;
         return;
      end
      a  = rf_m[i.rs1];
      b2 = rf_m[i.rs2];
      if (i.br) begin
         if (ref_taken(i.f3, a, b2)) begin
            be.cyc = 32'(cyc + 1);
            be.tgt = i.pc + i.imm;
            brq.push_back(be);
            skip = 2;
         end
         return;
      end
      res = ref_alu(i, a, i.asrc ? i.imm : b2);
      if (i.mw) mem_m[widx(res)] = b2;
      if (i.rw && i.rd != 5'd0) begin
         val = i.m2r ? mem_m[widx(res)] : res;
         rf_m[i.rd] = val;
         we.cyc = 32'(cyc + 3);
         we.rd  = i.rd;
         we.val = val;
         wbq.push_back(we);
      end
   endtask

   // ------------------------------------------------------------ stimulus helpers
   task automatic issue(input ins_t i, input bit use_model);
      logic [6:0] f7;
      @(negedge clk);
      f7 = 7'($urandom);
      f7[5] = i.f7b5;
      PC_ID = i.pc;  IMM_ID = i.imm;  FUNCT3_ID = i.f3;  FUNCT7_ID = f7;
      RD_ID = i.rd;  RS1_ID = i.rs1;  RS2_ID = i.rs2;
      REG_DATA1_ID = hw_rf[i.rs1];
      REG_DATA2_ID = hw_rf[i.rs2];
      RegWrite_ID = i.rw;  MemtoReg_ID = i.m2r;  MemRead_ID = i.mr;  MemWrite_ID = i.mw;
      ALUSrc_ID = i.asrc;  Branch_ID = i.br;  ALUop_ID = i.op;
      if (use_model) model(i);
   endtask

   function automatic ins_t nop();
      ins_t r;
      r = '0;
      return r;
   endfunction
   function automatic ins_t addi(input int rd, input int rs1, input logic [31:0] imm);
      ins_t r;
      r = '0; r.op = 2'b00; r.asrc = 1'b1; r.rw = 1'b1;
      r.rd = 5'(rd); r.rs1 = 5'(rs1); r.imm = imm;
      return r;
   endfunction
   function automatic ins_t rop(input logic [2:0] f3, input logic f7b5, input int rd, input int rs1, input int rs2);
      ins_t r;
      r = '0; r.op = 2'b10; r.rw = 1'b1; r.f3 = f3; r.f7b5 = f7b5;
      r.rd = 5'(rd); r.rs1 = 5'(rs1); r.rs2 = 5'(rs2);
      return r;
   endfunction
   function automatic ins_t sw(input int rs2, input int rs1, input logic [31:0] imm);
      ins_t r;
      r = '0; r.op = 2'b00; r.asrc = 1'b1; r.mw = 1'b1;
      r.rs1 = 5'(rs1); r.rs2 = 5'(rs2); r.imm = imm;
      return r;
   endfunction
   function automatic ins_t lw(input int rd, input int rs1, input logic [31:0] imm);
      ins_t r;
      r = addi(rd, rs1, imm);
      r.mr = 1'b1; r.m2r = 1'b1;
      return r;
   endfunction
   function automatic ins_t bra(input logic [2:0] f3, input int rs1, input int rs2,
                                input logic [31:0] pc, input logic [31:0] imm);
      ins_t r;
      r = '0; r.op = 2'b01; r.br = 1'b1; r.f3 = f3;
      r.rs1 = 5'(rs1); r.rs2 = 5'(rs2); r.pc = pc; r.imm = imm;
      return r;
   endfunction

   task automatic check_outputs_zero(input string tag);
      chk({tag, "_PCSrc"},       32'(PCSrc),       32'd0);
      chk({tag, "_PC_Branch"},   PC_Branch,        32'd0);
      chk({tag, "_RegWrite_WB"}, 32'(RegWrite_WB), 32'd0);
      chk({tag, "_ALU_DATA_WB"}, ALU_DATA_WB,      32'd0);
      chk({tag, "_RD_WB"},       32'(RD_WB),       32'd0);
      chk({tag, "_MemRead_EX"},  32'(MemRead_EX),  32'd0);
      chk({tag, "_RD_EX"},       32'(RD_EX),       32'd0);
   endtask

   // ------------------------------------------------------------ monitor
   initial begin
      wb_exp_t we;
      br_exp_t be;
      forever begin
         @(negedge clk);
         if (mon_en) begin
            if (RegWrite_WB) begin
               checks++;
               if (wbq.size() == 0) begin
                  errors++;
                  $display("FAIL wb_unexpected got rd=%0d data=%h cyc=%0d expected no write", RD_WB, ALU_DATA_WB, cyc);
               end else begin
                  we = wbq.pop_front();
                  if (RD_WB !== we.rd || ALU_DATA_WB !== we.val || 32'(cyc) != we.cyc) begin
                     errors++;
                     $display("FAIL wb got rd=%0d data=%h cyc=%0d expected rd=%0d data=%h cyc=%0d",
                              RD_WB, ALU_DATA_WB, cyc, we.rd, we.val, we.cyc);
                  end
               end
            end
            if (PCSrc) begin
               checks++;
               if (brq.size() == 0) begin
                  errors++;
                  $display("FAIL branch_unexpected got target=%h cyc=%0d expected not taken", PC_Branch, cyc);
               end else begin
                  be = brq.pop_front();
                  if (PC_Branch !== be.tgt || 32'(cyc) != be.cyc) begin
                     errors++;
                     $display("FAIL branch got target=%h cyc=%0d expected target=%h cyc=%0d",
                              PC_Branch, cyc, be.tgt, be.cyc);
                  end
               end
            end
         end
      end
   end

   // ------------------------------------------------------------ main sequence
   initial begin
      ins_t r;
      int   k;
      for (int i = 0; i < 32; i++) rf_m[i] = '0;
      for (int i = 0; i < DW; i++) mem_m[i] = '0;
      reset = 1'b1;
      PC_ID = '0; IMM_ID = '0; REG_DATA1_ID = '0; REG_DATA2_ID = '0;
      FUNCT3_ID = '0; FUNCT7_ID = '0; RD_ID = '0; RS1_ID = '0; RS2_ID = '0;
      RegWrite_ID = 1'b0; MemtoReg_ID = 1'b0; MemRead_ID = 1'b0; MemWrite_ID = 1'b0;
      ALUSrc_ID = 1'b0; Branch_ID = 1'b0; ALUop_ID = '0;

      repeat (3) @(posedge clk);
      @(negedge clk);
      check_outputs_zero("reset");
      reset = 1'b0;
      rf_clear = 1'b0;
      mon_en = 1'b1;

      // Give every memory word a known value.
      for (int i = 0; i < DW; i++) issue(sw(0, 0, 32'(i * 4)), 1'b1);

      // add x3 = x1 + x2 with 5 and 7
      issue(addi(1, 0, 32'd5), 1'b1);
      issue(addi(2, 0, 32'd7), 1'b1);
      repeat (4) issue(nop(), 1'b1);
      issue(rop(3'd0, 1'b0, 3, 1, 2), 1'b1);
      repeat (4) issue(nop(), 1'b1);

      // addi x1 = 4 then add x2 = x1 + x1, with 0, 1 and 2 bubbles between
      for (int gap = 0; gap < 3; gap++) begin
         issue(addi(1, 0, 32'd0), 1'b1);
         repeat (4) issue(nop(), 1'b1);
         issue(addi(1, 0, 32'd4), 1'b1);
         repeat (gap) issue(nop(), 1'b1);
         issue(rop(3'd0, 1'b0, 2, 1, 1), 1'b1);
         repeat (4) issue(nop(), 1'b1);
      end

      // store / load, including an address that wraps past the end of memory
      issue(addi(2, 0, 32'hDEADBEEF), 1'b1);
      issue(sw(2, 0, 32'd8), 1'b1);
      issue(lw(4, 0, 32'd8), 1'b1);
      issue(nop(), 1'b1);
      issue(lw(5, 0, 32'(8 + 4 * DW)), 1'b1);
      repeat (4) issue(nop(), 1'b1);

      // taken beq: the addi and the store behind it must vanish
      issue(addi(1, 0, 32'd9), 1'b1);
      issue(bra(3'd0, 1, 1, 32'h20, 32'h10), 1'b1);
      issue(addi(6, 0, 32'd77), 1'b1);
      issue(sw(1, 0, 32'h40), 1'b1);
      issue(lw(7, 0, 32'h40), 1'b1);
      repeat (4) issue(nop(), 1'b1);

      // signed vs unsigned greater-or-equal on -1 and 1
      issue(addi(6, 0, 32'hFFFF_FFFF), 1'b1);
      issue(addi(7, 0, 32'd1), 1'b1);
      issue(bra(3'd5, 6, 7, 32'h100, 32'h40), 1'b1);
      issue(nop(), 1'b1);
      chk("bge_signed_not_taken", 32'(PCSrc), 32'd0);
      issue(nop(), 1'b1);
      issue(bra(3'd7, 6, 7, 32'h200, 32'h40), 1'b1);
      issue(nop(), 1'b1);
      chk("bgeu_taken", 32'(PCSrc), 32'd1);
      repeat (4) issue(nop(), 1'b1);

      // reset lands while a store sits in MEM: the store must not happen
      issue(sw(2, 0, 32'd16), 1'b0);
      issue(nop(), 1'b0);
      issue(nop(), 1'b0);
      reset = 1'b1;
      @(negedge clk);
      check_outputs_zero("reset_store");
      reset = 1'b0;
      issue(lw(8, 0, 32'd16), 1'b1);
      repeat (4) issue(nop(), 1'b1);

      // random traffic over a small register pool to force hazards
      for (int n = 0; n < 400; n++) begin
         k = $urandom_range(0, 6);
         case (k)
            0: issue(rop(3'($urandom), 1'($urandom), $urandom_range(0, 7),
                         $urandom_range(0, 7), $urandom_range(0, 7)), 1'b1);
            1: begin
               r = rop(3'($urandom), 1'($urandom), $urandom_range(0, 7), $urandom_range(0, 7), 0);
               r.asrc = 1'b1;
               r.imm = $urandom;
               issue(r, 1'b1);
            end
            2: issue(addi($urandom_range(0, 7), $urandom_range(0, 7), $urandom), 1'b1);
            3: issue(sw($urandom_range(0, 7), $urandom_range(0, 7), $urandom), 1'b1);
            4: begin
               issue(lw($urandom_range(0, 7), $urandom_range(0, 7), $urandom), 1'b1);
               issue(nop(), 1'b1);
            end
            5: issue(bra(3'($urandom), $urandom_range(0, 7), $urandom_range(0, 7),
                         $urandom, $urandom), 1'b1);
            default: issue(nop(), 1'b1);
         endcase
      end

      repeat (6) issue(nop(), 1'b1);
      @(negedge clk);
      chk("wb_queue_drained", 32'(wbq.size()), 32'd0);
      chk("branch_queue_drained", 32'(brq.size()), 32'd0);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
